pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Upstream controller for the PLL primitive. Drives PLL_EN and watches the PLL's LOCK output.
//  On a lock timeout it power-cycles the PLL (PLL_EN low, then high) and retries, up to a fixed limit.
//  Holds the downstream clock-domain reset until lock has been stable for a set time.
//  Runs on the PLL reference clock, so PLL_EN and CLK_IN stay phase-aligned.
// PARAMETERS
//  SYNC_STAGES    2     flops in the PLL_LOCK synchronizer; range 2-4
//  LOCK_TIMEOUT   1024  CLK_IN cycles allowed from PLL_EN rise to first synced lock; must exceed PLL lock time (500)
//  STABLE_CYCLES  16    consecutive synced-lock cycles required before READY; range 1-255
//  OFF_CYCLES     8     CLK_IN cycles PLL_EN is held low between retries; range 1-255
//  MAX_RETRIES    3     retries after the first attempt before FAIL; range 0-15
// PORTS
//  CLK_IN       in   1  reference clock (same net that feeds the PLL)
//  RESET        in   1  synchronous, active-high reset
//  START        in   1  level request; high = bring up the PLL, low = shut it down
//  PLL_LOCK     in   1  LOCK from the PLL; treated as asynchronous
//  PLL_EN       out  1  PLL enable
//  READY        out  1  lock achieved and stable
//  DOMAIN_RST   out  1  reset for logic clocked by CLK_OUT; equals ~READY
//  FAIL         out  1  retries exhausted; sticky until START goes low or RESET
//  RETRY_CNT    out  4  retries used in the current bring-up
//  LOCK_LOST    out  1  one-cycle pulse when lock drops while in LOCKED
// BEHAVIOUR
//  Reset: state=IDLE; PLL_EN=0, READY=0, DOMAIN_RST=1, FAIL=0, RETRY_CNT=0, LOCK_LOST=0; sync chain cleared.
//  All outputs are registered. lock_s = PLL_LOCK after SYNC_STAGES flops.
//  IDLE: START=1 -> ENABLE; PLL_EN=1 from the next cycle; timer cleared.
//  ENABLE: timer counts each cycle.
//    lock_s=1 -> STABLE.
//    Timer reaches LOCK_TIMEOUT-1 with lock_s=0:
//      RETRY_CNT<MAX_RETRIES -> OFF, RETRY_CNT+1;
//      otherwise -> FAILED.
//  STABLE: counts consecutive lock_s=1 cycles.
//    lock_s=0 -> back to ENABLE; stable count cleared; timeout timer not cleared.
//    Count reaches STABLE_CYCLES -> LOCKED; READY=1 and DOMAIN_RST=0 on the cycle of entry.
//  LOCKED: lock_s=0 -> LOCK_LOST pulses for 1 cycle; READY=0 and DOMAIN_RST=1 the same cycle;
//    -> ENABLE with the timer cleared. PLL_EN stays high. RETRY_CNT is unchanged.
//  OFF: PLL_EN=0 for exactly OFF_CYCLES cycles, then -> ENABLE with the timer cleared.
//  FAILED: PLL_EN=0, FAIL=1, READY=0. Leaves only when START=0 -> IDLE.
//  START=0 in any state: -> IDLE next cycle; PLL_EN=0, READY=0, DOMAIN_RST=1, FAIL=0, RETRY_CNT=0.
//    START=0 takes priority over every other transition in the same cycle.
//  START high again while in IDLE: a fresh bring-up with RETRY_CNT=0.
//  Simultaneous lock_s=1 and timeout in ENABLE: lock wins -> STABLE.
//  RESET asserted mid-operation: reset values apply the next cycle; PLL_EN drops immediately.
//  Counters saturate and never wrap. Timer width = $clog2(LOCK_TIMEOUT+1); stable and off counters are 8 bits.
//  Latency, START rise to PLL_EN=1: 1 cycle.
//  Latency, PLL_LOCK rise to READY: SYNC_STAGES + STABLE_CYCLES + 1 cycles.
// STRUCTURE
//  Shared package pll_seq_pkg:
//    typedef enum logic [2:0] {IDLE, ENABLE, STABLE, LOCKED, OFF, FAILED} pll_seq_state_t;
//    localparams SEQ_CNT_W=8 and RETRY_W=4.
//  Sub-module sync_ff #(.STAGES(SYNC_STAGES)): a generic synchronizer, reused for other async status inputs.
//  Top level: one FSM always_ff block, plus the timer, stable counter, off counter and retry counter.
// TESTING
//  1 Nominal: START=1, PLL_LOCK rises 600 cycles after PLL_EN -> READY at cycle 600+2+16+1; RETRY_CNT=0; FAIL=0.
//  2 Retry: PLL_LOCK held 0, MAX_RETRIES=3 -> PLL_EN shows 4 high windows of 1024 cycles, separated by
//    3 low gaps of 8 cycles each; then FAIL=1, RETRY_CNT=3, PLL_EN=0.
//  3 Glitch: PLL_LOCK high 10 cycles, low 1, high again, with STABLE_CYCLES=16 -> READY is not asserted
//    until 16 uninterrupted lock cycles; no timer reset.
//  4 Lock loss: drop PLL_LOCK in LOCKED -> LOCK_LOST 1-cycle pulse at sync+1; READY=0; PLL_EN stays 1;
//    relock -> READY again.
//  5 Abort: START=0 during STABLE and during OFF -> IDLE next cycle, all outputs at reset values;
//    START=1 again -> RETRY_CNT restarts at 0.
//  6 Reset mid-LOCKED: RESET=1 for 1 cycle -> PLL_EN=0, DOMAIN_RST=1 the next cycle;
//    with START still 1, bring-up restarts after RESET falls.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
//   pll_seq_state_t : sequencer FSM states
//   SEQ_CNT_W       : width of the stable and off counters
//   RETRY_W         : width of the retry counter / RETRY_CNT
package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENABLE,
        STABLE,
        LOCKED,
        OFF,
        FAILED
    } pll_seq_state_t;

    localparam int unsigned SEQ_CNT_W = 8;
    localparam int unsigned RETRY_W   = 4;

    // States in which the PLL is powered.
    function automatic logic pll_powered(input pll_seq_state_t st);
        return (st == ENABLE) || (st == STABLE) || (st == LOCKED);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings.
//   START      : bring-up request (level)
//   PLL_LOCK   : LOCK from the PLL, asynchronous
//   PLL_EN     : PLL enable
//   READY      : lock achieved and stable
//   DOMAIN_RST : reset for the CLK_OUT domain (~READY)
//   FAIL       : retries exhausted, sticky until START low
//   RETRY_CNT  : retries used in the current bring-up
//   LOCK_LOST  : one-cycle pulse on lock loss in LOCKED
// master = sequencer side, slave = environment side.
interface pll_lock_sequencer_if
    import pll_seq_pkg::*;
();

    logic               START;
    logic               PLL_LOCK;
    logic               PLL_EN;
    logic               READY;
    logic               DOMAIN_RST;
    logic               FAIL;
    logic [RETRY_W-1:0] RETRY_CNT;
    logic               LOCK_LOST;

    modport master (
        input  START,
        input  PLL_LOCK,
        output PLL_EN,
        output READY,
        output DOMAIN_RST,
        output FAIL,
        output RETRY_CNT,
        output LOCK_LOST
    );

    modport slave (
        output START,
        output PLL_LOCK,
        input  PLL_EN,
        input  READY,
        input  DOMAIN_RST,
        input  FAIL,
        input  RETRY_CNT,
        input  LOCK_LOST
    );

endinterface

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for asynchronous single-bit status inputs.
//   CLK_IN   : destination clock
//   RESET    : synchronous active-high reset, clears the chain
//   async_in : asynchronous input
//   sync_out : input after STAGES flops (STAGES must be 2 or more)
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK_IN,
    input  logic RESET,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: enables the PLL, waits for a stable lock, power-cycles
// and retries on lock timeout, and holds the CLK_OUT-domain reset until locked.
//   CLK_IN : PLL reference clock
//   RESET  : synchronous active-high reset
//   bus    : control/status bundle (see pll_lock_sequencer_if)
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned OFF_CYCLES    = 8,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                 CLK_IN,
    input  logic                 RESET,
    pll_lock_sequencer_if.master bus
);

    localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [TMR_W-1:0]     TMR_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]     TMR_MAX     = TMR_W'(LOCK_TIMEOUT);
    localparam logic [SEQ_CNT_W-1:0] STABLE_LAST = SEQ_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [SEQ_CNT_W-1:0] OFF_LAST    = SEQ_CNT_W'(OFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t       state_q, state_nxt;
    logic [TMR_W-1:0]     timer_q, timer_nxt;
    logic [SEQ_CNT_W-1:0] stable_q, stable_nxt;
    logic [SEQ_CNT_W-1:0] off_q, off_nxt;
    logic [RETRY_W-1:0]   retry_q, retry_nxt;
    logic                 lock_lost_nxt;
    logic                 lock_s;

    logic pll_en_q;
    logic ready_q;
    logic domain_rst_q;
    logic fail_q;
    logic lock_lost_q;

    // LOCK crosses in from the PLL analog block.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .CLK_IN   (CLK_IN),
        .RESET    (RESET),
        .async_in (bus.PLL_LOCK),
        .sync_out (lock_s)
    );

    // Next-state and counter update.
    always_comb begin
        state_nxt     = state_q;
        timer_nxt     = timer_q;
        stable_nxt    = stable_q;
        off_nxt       = off_q;
        retry_nxt     = retry_q;
        lock_lost_nxt = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = ENABLE;
                    timer_nxt = '0;
                    retry_nxt = '0;
                end
            end
            ENABLE: begin
                // Timer only advances in ENABLE; a lock glitch in STABLE holds it.
                if (timer_q != TMR_MAX) begin
                    timer_nxt = timer_q + TMR_W'(1);
                end
                if (lock_s) begin
                    state_nxt  = STABLE;
                    stable_nxt = '0;
                end else if (timer_q == TMR_LAST) begin
                    if (retry_q < RETRY_LIMIT) begin
                        state_nxt = OFF;
                        retry_nxt = retry_q + RETRY_W'(1);
                        off_nxt   = '0;
                    end else begin
                        state_nxt = FAILED;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt  = ENABLE;
                    stable_nxt = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_nxt = LOCKED;
                end else if (stable_q != '1) begin
                    stable_nxt = stable_q + SEQ_CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    state_nxt     = ENABLE;
                    timer_nxt     = '0;
                    lock_lost_nxt = 1'b1;
                end
            end
            OFF: begin
                if (off_q == OFF_LAST) begin
                    state_nxt = ENABLE;
                    timer_nxt = '0;
                end else if (off_q != '1) begin
                    off_nxt = off_q + SEQ_CNT_W'(1);
                end
            end
            FAILED: begin
                state_nxt = FAILED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Dropping START overrides every other transition.
        if (!bus.START) begin
            state_nxt     = IDLE;
            timer_nxt     = '0;
            stable_nxt    = '0;
            off_nxt       = '0;
            retry_nxt     = '0;
            lock_lost_nxt = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            stable_q     <= '0;
            off_q        <= '0;
            retry_q      <= '0;
            pll_en_q     <= 1'b0;
            ready_q      <= 1'b0;
            domain_rst_q <= 1'b1;
            fail_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            timer_q      <= timer_nxt;
            stable_q     <= stable_nxt;
            off_q        <= off_nxt;
            retry_q      <= retry_nxt;
            pll_en_q     <= pll_powered(state_nxt);
            ready_q      <= (state_nxt == LOCKED);
            domain_rst_q <= (state_nxt != LOCKED);
            fail_q       <= (state_nxt == FAILED);
            lock_lost_q  <= lock_lost_nxt;
        end
    end

    assign bus.PLL_EN     = pll_en_q;
    assign bus.READY      = ready_q;
    assign bus.DOMAIN_RST = domain_rst_q;
    assign bus.FAIL       = fail_q;
    assign bus.RETRY_CNT  = retry_q;
    assign bus.LOCK_LOST  = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized bench for pll_lock_sequencer with default parameters. Expected
// event times are computed arithmetically from the sequencing rules.
module tb_pll_lock_sequencer;

    localparam int SYNC   = 2;
    localparam int TO     = 1024;
    localparam int STAB   = 16;
    localparam int OFFC   = 8;
    localparam int MAXR   = 3;
    localparam int LAT    = SYNC + STAB + 1;   // lock edge to READY
    localparam int PERIOD = TO + OFFC;         // one failed attempt incl. off gap

    localparam int W_READY = 0;
    localparam int W_EN_LO = 1;
    localparam int W_LL    = 2;

    logic clk = 1'b0;
    logic rst;

    pll_lock_sequencer_if bus_if ();

    pll_lock_sequencer dut (
        .CLK_IN (clk),
        .RESET  (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_pass    = 0;
    int ll_pulses = 0;
    int ll_wide   = 0;
    int dr_errs   = 0;
    bit ll_prev   = 1'b0;
    int rise_t[$];
    int fall_t[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit sig_hit(input int w);
        case (w)
            W_READY: return bus_if.READY === 1'b1;
            W_EN_LO: return bus_if.PLL_EN === 1'b0;
            W_LL:    return bus_if.LOCK_LOST === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Steps until the selected condition holds; n = steps taken, -1 if budget expires.
    task automatic wait_for(input int w, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (sig_hit(w)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pll_en"},     int'(bus_if.PLL_EN),     0);
        chk({tag, "_ready"},      int'(bus_if.READY),      0);
        chk({tag, "_domain_rst"}, int'(bus_if.DOMAIN_RST), 1);
        chk({tag, "_fail"},       int'(bus_if.FAIL),       0);
        chk({tag, "_retry"},      int'(bus_if.RETRY_CNT),  0);
        chk({tag, "_lock_lost"},  int'(bus_if.LOCK_LOST),  0);
    endtask

    // Return to IDLE, then start a fresh bring-up; leaves us one step after PLL_EN rises.
    task automatic restart();
        bus_if.START    = 1'b0;
        bus_if.PLL_LOCK = 1'b0;
        step(2);
        bus_if.START = 1'b1;
        step(1);
        chk("start_to_pll_en", int'(bus_if.PLL_EN), 1);
    endtask

    // Continuous observations: DOMAIN_RST mirrors READY, LOCK_LOST is single-cycle.
    always @(negedge clk) begin
        if (bus_if.DOMAIN_RST !== ~bus_if.READY) dr_errs++;
        if (bus_if.LOCK_LOST === 1'b1 && !ll_prev) ll_pulses++;
        if (bus_if.LOCK_LOST === 1'b1 && ll_prev) ll_wide++;
        ll_prev = (bus_if.LOCK_LOST === 1'b1);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, d, h, k, o;
        logic prev;

        rst             = 1'b1;
        bus_if.START    = 1'b0;
        bus_if.PLL_LOCK = 1'b0;
        step(2);
        check_idle("reset");
        rst = 1'b0;
        step(5);
        chk("idle_no_start", int'(bus_if.PLL_EN), 0);

        // Nominal bring-up, then lock loss and relock.
        restart();
        d = $urandom_range(520, 900);
        step(d);
        bus_if.PLL_LOCK = 1'b1;
        wait_for(W_READY, 60, n);
        chk("nominal_ready_latency", n, LAT);
        chk("nominal_retry", int'(bus_if.RETRY_CNT), 0);
        chk("nominal_fail", int'(bus_if.FAIL), 0);
        chk("nominal_domain_rst", int'(bus_if.DOMAIN_RST), 0);
        step($urandom_range(1, 20));
        bus_if.PLL_LOCK = 1'b0;
        wait_for(W_LL, 10, n);
        chk("lock_lost_delay", n, SYNC + 1);
        chk("lost_ready", int'(bus_if.READY), 0);
        chk("lost_pll_en", int'(bus_if.PLL_EN), 1);
        chk("lost_domain_rst", int'(bus_if.DOMAIN_RST), 1);
        step(1);
        chk("lost_pulse_width", int'(bus_if.LOCK_LOST), 0);
        step($urandom_range(1, 40));
        bus_if.PLL_LOCK = 1'b1;
        wait_for(W_READY, 60, n);
        chk("relock_latency", n, LAT);

        // Lock seen on the same cycle as the timeout: lock wins.
        restart();
        step(TO - SYNC - 1);
        bus_if.PLL_LOCK = 1'b1;
        wait_for(W_READY, 60, n);
        chk("edge_lock_wins", n, LAT);
        chk("edge_lock_retry", int'(bus_if.RETRY_CNT), 0);

        // Lock one cycle too late: timeout, off gap, then lock on the retry.
        restart();
        step(TO - SYNC);
        bus_if.PLL_LOCK = 1'b1;
        wait_for(W_EN_LO, 10, n);
        chk("edge_timeout", n, SYNC);
        chk("edge_timeout_retry", int'(bus_if.RETRY_CNT), 1);
        wait_for(W_READY, 60, n);
        chk("lock_after_off", n, OFFC + 1 + STAB);

        // Lock on a random later attempt; RETRY_CNT survives a lock loss.
        for (int t = 0; t < 2; t++) begin
            k = $urandom_range(1, MAXR);
            d = $urandom_range(100, 900);
            restart();
            step(k * PERIOD + d);
            bus_if.PLL_LOCK = 1'b1;
            wait_for(W_READY, 60, n);
            chk("retry_lock_latency", n, LAT);
            chk("retry_lock_cnt", int'(bus_if.RETRY_CNT), k);
            bus_if.PLL_LOCK = 1'b0;
            wait_for(W_LL, 10, n);
            chk("retry_lock_lost_delay", n, SYNC + 1);
            step(2);
            chk("retry_kept_after_loss", int'(bus_if.RETRY_CNT), k);
        end

        // No lock at all: four enable windows, three gaps, then FAIL.
        restart();
        rise_t.delete();
        fall_t.delete();
        prev = 1'b1;
        n    = -1;
        for (int i = 1; i <= 5000; i++) begin
            step(1);
            if (bus_if.PLL_EN !== prev) begin
                if (bus_if.PLL_EN === 1'b1) rise_t.push_back(i);
                else fall_t.push_back(i);
                prev = bus_if.PLL_EN;
            end
            if (bus_if.FAIL === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("fail_time", n, (MAXR + 1) * TO + MAXR * OFFC);
        chk("fail_falls", fall_t.size(), MAXR + 1);
        chk("fail_rises", rise_t.size(), MAXR);
        for (int i = 0; i < fall_t.size() && i <= MAXR; i++)
            chk("fail_fall_at", fall_t[i], TO + i * PERIOD);
        for (int i = 0; i < rise_t.size() && i < MAXR; i++)
            chk("fail_rise_at", rise_t[i], (i + 1) * PERIOD);
        chk("fail_retry", int'(bus_if.RETRY_CNT), MAXR);
        chk("fail_pll_en", int'(bus_if.PLL_EN), 0);
        chk("fail_ready", int'(bus_if.READY), 0);
        step(20);
        chk("fail_sticky", int'(bus_if.FAIL), 1);
        bus_if.START = 1'b0;
        step(1);
        check_idle("fail_cleared");

        // Single-cycle lock glitch restarts the stable count.
        restart();
        k = ll_pulses;
        d = $urandom_range(200, 800);
        step(d);
        bus_if.PLL_LOCK = 1'b1;
        h = $urandom_range(1, STAB);
        step(h);
        bus_if.PLL_LOCK = 1'b0;
        step(1);
        chk("glitch_not_ready", int'(bus_if.READY), 0);
        bus_if.PLL_LOCK = 1'b1;
        wait_for(W_READY, 60, n);
        chk("glitch_ready", n, LAT);
        chk("glitch_no_lock_lost", ll_pulses - k, 0);

        // Brief lock then loss: the timeout budget is not restarted.
        restart();
        step(900);
        bus_if.PLL_LOCK = 1'b1;
        h = $urandom_range(2, 10);
        step(h);
        bus_if.PLL_LOCK = 1'b0;
        wait_for(W_EN_LO, 300, n);
        chk("glitch_timer_kept", n, TO - 900);
        chk("glitch_timer_retry", int'(bus_if.RETRY_CNT), 1);

        // Abort in STABLE, at random and on the cycle that would enter LOCKED.
        restart();
        d = $urandom_range(100, 800);
        step(d);
        bus_if.PLL_LOCK = 1'b1;
        step(SYNC + 1 + $urandom_range(1, 10));
        bus_if.START = 1'b0;
        step(1);
        check_idle("abort_stable");
        restart();
        step(d);
        bus_if.PLL_LOCK = 1'b1;
        step(SYNC + STAB);
        bus_if.START = 1'b0;
        step(1);
        check_idle("abort_vs_locked");

        // Abort in OFF, then a fresh bring-up starts counting retries from zero.
        restart();
        step(TO);
        chk("off_entry_retry", int'(bus_if.RETRY_CNT), 1);
        chk("off_entry_pll_en", int'(bus_if.PLL_EN), 0);
        o = $urandom_range(0, OFFC - 1);
        step(o);
        bus_if.START = 1'b0;
        step(1);
        check_idle("abort_off");
        bus_if.START = 1'b1;
        step(1);
        chk("fresh_pll_en", int'(bus_if.PLL_EN), 1);
        chk("fresh_retry", int'(bus_if.RETRY_CNT), 0);
        wait_for(W_EN_LO, TO + 10, n);
        chk("fresh_timeout", n, TO);
        chk("fresh_retry_after", int'(bus_if.RETRY_CNT), 1);

        // Reset while LOCKED with START held high.
        restart();
        d = $urandom_range(100, 800);
        step(d);
        bus_if.PLL_LOCK = 1'b1;
        wait_for(W_READY, 60, n);
        chk("pre_reset_ready", n, LAT);
        rst = 1'b1;
        step(1);
        chk("reset_pll_en", int'(bus_if.PLL_EN), 0);
        chk("reset_domain_rst", int'(bus_if.DOMAIN_RST), 1);
        chk("reset_ready", int'(bus_if.READY), 0);
        rst = 1'b0;
        step(1);
        chk("post_reset_pll_en", int'(bus_if.PLL_EN), 1);
        wait_for(W_READY, 60, n);
        chk("post_reset_ready", n, SYNC + STAB);

        step(2);
        chk("domain_rst_tracks_ready", dr_errs, 0);
        chk("lock_lost_pulses", ll_pulses, 3);
        chk("lock_lost_wide", ll_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
